// File: rtl/spell_bridge_pkg.sv
// Shared types and constants for the spell host bridge.
// Covers FSM states, access kinds, CSR offsets and the error read value.
package spell_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        KindWb,
        KindCsr,
        KindLaWr,
        KindLaRd
    } kind_e;

    localparam logic [1:0]  CsrStatus   = 2'd0;
    localparam logic [1:0]  CsrMask     = 2'd1;
    localparam logic [1:0]  CsrInfo     = 2'd2;
    localparam logic [7:0]  InfoVersion = 8'h01;
    localparam logic [31:0] ErrData     = 32'hFFFF_FFFF;

endpackage

// File: rtl/spell_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse on the synchronised level.
module spell_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/spell_host_bridge.sv
// Arbitrates Wishbone and logic-analyzer access onto one core request/ready port,
// with a bus timeout, sticky interrupt status/mask CSRs and LA read-back.
module spell_host_bridge
    import spell_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IRQ_SRC = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_la_wb_disable,
    input  logic               i_la_write,
    input  logic [ADDR_W-1:0]  i_la_addr,
    input  logic [DATA_W-1:0]  i_la_data,
    output logic [DATA_W-1:0]  o_la_rdata,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [3:0]         i_wb_sel,
    input  logic [31:0]        i_wb_addr,
    input  logic [31:0]        i_wb_data,
    output logic               o_wb_ack,
    output logic [31:0]        o_wb_data,
    output logic               o_core_req,
    output logic               o_core_we,
    output logic [ADDR_W-1:0]  o_core_addr,
    output logic [DATA_W-1:0]  o_core_wdata,
    input  logic               i_core_ready,
    input  logic [DATA_W-1:0]  i_core_rdata,
    input  logic [IRQ_SRC-1:0] i_irq_src,
    output logic               o_interrupt
);

    localparam int unsigned SW   = IRQ_SRC + 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    state_e            state_q, state_d;
    kind_e             kind_q;
    logic              we_q, abort_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] core_wdata_q;
    logic [1:0]        csr_off_q;
    logic [SW-1:0]     csr_wdata_q;
    logic [31:0]       rdata_q;
    logic [CntW-1:0]   cnt_q;
    logic [SW-1:0]     status_q, status_d, mask_q;
    logic [IRQ_SRC-1:0] irq_prev_q, irq_rise;
    logic              int_q;

    logic [ADDR_W-1:0] la_addr_s1, la_addr_s2, la_wr_addr_q, last_rd_addr_q;
    logic [DATA_W-1:0] la_data_s1, la_data_s2, la_wr_data_q, la_rdata_q;
    logic              la_wr_pend_q, la_rd_pend_q;
    logic              la_own, la_wr_rise, unused_own_rise;

    logic        wb_req, wb_is_csr, wb_core_go;
    logic        take_la_wr, take_la_rd, take_wb, core_done, timeout_hit;
    logic [31:0] csr_rdata, info_word;
    logic        unused_wb_bits;

    spell_sync_edge u_sync_la_write (
        .clock (clock),
        .reset (reset),
        .d     (i_la_write),
        .level (),
        .rise  (la_wr_rise)
    );

    spell_sync_edge u_sync_la_own (
        .clock (clock),
        .reset (reset),
        .d     (i_la_wb_disable),
        .level (la_own),
        .rise  (unused_own_rise)
    );

    assign unused_wb_bits = ^{i_wb_addr, i_wb_data, i_wb_sel};

    assign wb_req     = i_wb_cyc & i_wb_stb;
    assign wb_is_csr  = i_wb_addr[ADDR_W+2];
    // Sub-byte writes and LA-owned core accesses complete without touching the core.
    assign wb_core_go = !wb_is_csr && !la_own && !(i_wb_we && !i_wb_sel[0]);
    assign irq_rise   = i_irq_src & ~irq_prev_q;
    assign info_word  = {8'(IRQ_SRC), 8'(DATA_W), 8'(ADDR_W), InfoVersion};

    always_comb begin
        csr_rdata = '0;
        case (i_wb_addr[3:2])
            CsrStatus: csr_rdata = 32'(status_q);
            CsrMask:   csr_rdata = 32'(mask_q);
            CsrInfo:   csr_rdata = info_word;
            default:   csr_rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        take_la_wr  = 1'b0;
        take_la_rd  = 1'b0;
        take_wb     = 1'b0;
        core_done   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (la_own && la_wr_pend_q) begin
                    take_la_wr = 1'b1;
                    state_d    = StIssue;
                end else if (la_own && (la_rd_pend_q || la_addr_s2 != last_rd_addr_q)) begin
                    take_la_rd = 1'b1;
                    state_d    = StIssue;
                end else if (wb_req) begin
                    take_wb = 1'b1;
                    state_d = wb_core_go ? StIssue : StResp;
                end
            end
            StIssue: begin
                if (i_core_ready) begin
                    core_done = 1'b1;
                    state_d   = StResp;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A source edge wins over a same-cycle W1C of its status bit.
    always_comb begin
        status_d = status_q;
        if (state_q == StResp && kind_q == KindCsr && we_q && csr_off_q == CsrStatus) begin
            status_d = status_d & ~csr_wdata_q;
        end
        status_d[IRQ_SRC-1:0] = status_d[IRQ_SRC-1:0] | irq_rise;
        if (timeout_hit) begin
            status_d[IRQ_SRC] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            kind_q         <= KindWb;
            we_q           <= 1'b0;
            abort_q        <= 1'b0;
            addr_q         <= '0;
            core_wdata_q   <= '0;
            csr_off_q      <= '0;
            csr_wdata_q    <= '0;
            rdata_q        <= '0;
            cnt_q          <= '0;
            status_q       <= '0;
            mask_q         <= '0;
            irq_prev_q     <= '0;
            int_q          <= 1'b0;
            la_addr_s1     <= '0;
            la_addr_s2     <= '0;
            la_data_s1     <= '0;
            la_data_s2     <= '0;
            la_wr_addr_q   <= '0;
            la_wr_data_q   <= '0;
            la_wr_pend_q   <= 1'b0;
            la_rd_pend_q   <= 1'b0;
            last_rd_addr_q <= '0;
            la_rdata_q     <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            irq_prev_q <= i_irq_src;
            int_q      <= |(status_q & mask_q);
            la_addr_s1 <= i_la_addr;
            la_addr_s2 <= la_addr_s1;
            la_data_s1 <= i_la_data;
            la_data_s2 <= la_data_s1;
            cnt_q      <= (state_q == StIssue) ? cnt_q + CntW'(1) : CntW'(1);

            if (state_q == StResp && kind_q == KindCsr && we_q && csr_off_q == CsrMask) begin
                mask_q <= csr_wdata_q;
            end

            if (take_la_wr) begin
                la_wr_pend_q <= 1'b0;
            end else if (la_wr_rise && !la_wr_pend_q) begin
                la_wr_pend_q <= 1'b1;
                la_wr_addr_q <= la_addr_s2;
                la_wr_data_q <= la_data_s2;
            end

            if (take_la_rd) begin
                la_rd_pend_q <= 1'b0;
            end else if (state_q == StResp && kind_q == KindLaWr) begin
                la_rd_pend_q <= 1'b1;
            end

            if (take_la_wr) begin
                kind_q       <= KindLaWr;
                we_q         <= 1'b1;
                addr_q       <= la_wr_addr_q;
                core_wdata_q <= la_wr_data_q;
                abort_q      <= 1'b0;
                rdata_q      <= '0;
            end else if (take_la_rd) begin
                kind_q  <= KindLaRd;
                we_q    <= 1'b0;
                addr_q  <= la_addr_s2;
                abort_q <= 1'b0;
                rdata_q <= '0;
            end else if (take_wb) begin
                kind_q       <= wb_is_csr ? KindCsr : KindWb;
                we_q         <= i_wb_we;
                addr_q       <= i_wb_addr[ADDR_W+1:2];
                core_wdata_q <= i_wb_data[DATA_W-1:0];
                csr_off_q    <= i_wb_addr[3:2];
                csr_wdata_q  <= i_wb_data[SW-1:0];
                abort_q      <= 1'b0;
                rdata_q      <= (wb_is_csr && !i_wb_we) ? csr_rdata : '0;
            end

            if (core_done) begin
                rdata_q <= we_q ? '0 : 32'(i_core_rdata);
            end else if (timeout_hit) begin
                rdata_q <= ErrData;
            end

            // Master gave up the cycle: let the core access finish but suppress the ack.
            if (state_q == StIssue && kind_q == KindWb && !i_wb_cyc) begin
                abort_q <= 1'b1;
            end

            if (state_q == StResp && kind_q == KindLaRd) begin
                la_rdata_q     <= rdata_q[DATA_W-1:0];
                last_rd_addr_q <= addr_q;
            end
        end
    end

    assign o_core_req   = (state_q == StIssue);
    assign o_core_we    = o_core_req & we_q;
    assign o_core_addr  = o_core_req ? addr_q : '0;
    assign o_core_wdata = o_core_req ? core_wdata_q : '0;
    assign o_wb_ack     = (state_q == StResp) && (kind_q == KindWb || kind_q == KindCsr)
                          && !abort_q;
    assign o_wb_data    = o_wb_ack ? rdata_q : '0;
    assign o_la_rdata   = la_rdata_q;
    assign o_interrupt  = int_q;

endmodule

// File: tb/tb_spell_host_bridge.sv
// Directed bench for spell_host_bridge with a behavioural core memory and
// scoreboards for Wishbone read data and core writes.
module tb_spell_host_bridge;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int IRQ_SRC = 1;
    localparam int TIMEOUT = 15;

    logic               clock = 1'b0;
    logic               reset;
    logic               i_la_wb_disable, i_la_write;
    logic [ADDR_W-1:0]  i_la_addr;
    logic [DATA_W-1:0]  i_la_data;
    logic [DATA_W-1:0]  o_la_rdata;
    logic               i_wb_cyc, i_wb_stb, i_wb_we;
    logic [3:0]         i_wb_sel;
    logic [31:0]        i_wb_addr, i_wb_data;
    logic               o_wb_ack;
    logic [31:0]        o_wb_data;
    logic               o_core_req, o_core_we;
    logic [ADDR_W-1:0]  o_core_addr;
    logic [DATA_W-1:0]  o_core_wdata;
    logic               i_core_ready;
    logic [DATA_W-1:0]  i_core_rdata;
    logic [IRQ_SRC-1:0] i_irq_src;
    logic               o_interrupt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0]        mem [2**ADDR_W];
    int                       core_delay = 1;
    bit                       core_never = 1'b0;
    int                       wait_cnt   = 0;
    logic [ADDR_W+DATA_W-1:0] cw_q [$];
    logic [31:0]              wb_q [$];

    always #5 clock = ~clock;

    spell_host_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IRQ_SRC (IRQ_SRC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .i_la_wb_disable (i_la_wb_disable),
        .i_la_write      (i_la_write),
        .i_la_addr       (i_la_addr),
        .i_la_data       (i_la_data),
        .o_la_rdata      (o_la_rdata),
        .i_wb_cyc        (i_wb_cyc),
        .i_wb_stb        (i_wb_stb),
        .i_wb_we         (i_wb_we),
        .i_wb_sel        (i_wb_sel),
        .i_wb_addr       (i_wb_addr),
        .i_wb_data       (i_wb_data),
        .o_wb_ack        (o_wb_ack),
        .o_wb_data       (o_wb_data),
        .o_core_req      (o_core_req),
        .o_core_we       (o_core_we),
        .o_core_addr     (o_core_addr),
        .o_core_wdata    (o_core_wdata),
        .i_core_ready    (i_core_ready),
        .i_core_rdata    (i_core_rdata),
        .i_irq_src       (i_irq_src),
        .o_interrupt     (o_interrupt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Core model: ready after core_delay request cycles; writes checked against cw_q.
    initial begin
        logic [ADDR_W+DATA_W-1:0] e;
        i_core_ready = 1'b0;
        i_core_rdata = '0;
        forever begin
            @(negedge clock);
            if (o_core_req && !reset) begin
                wait_cnt++;
                if (!core_never && wait_cnt >= core_delay) begin
                    i_core_ready = 1'b1;
                    if (o_core_we) begin
                        if (cw_q.size() == 0) begin
                            chk("core_write_unexpected", 32'(cw_q.size()), 32'd1);
                        end else begin
                            e = cw_q.pop_front();
                            chk("core_write", 32'({o_core_addr, o_core_wdata}), 32'(e));
                        end
                        mem[o_core_addr] = o_core_wdata;
                    end
                    i_core_rdata = mem[o_core_addr];
                end else begin
                    i_core_ready = 1'b0;
                end
            end else begin
                i_core_ready = 1'b0;
                i_core_rdata = '0;
                wait_cnt     = 0;
            end
        end
    end

    task automatic wb_xfer(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           input logic [31:0] exp_data, input int exp_lat, input bit irq_at_ack);
        int          n;
        bit          got;
        logic [31:0] e;
        wb_q.push_back(exp_data);
        @(posedge clock);
        #1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        i_wb_sel  = sel;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clock);
            #1;
            n++;
            got = o_wb_ack;
        end
        if (got && irq_at_ack) i_irq_src = '1;
        e = wb_q.pop_front();
        chk({tag, "_ack"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_data"}, o_wb_data, e);
            if (exp_lat > 0) chk({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge clock);
        #1;
        chk({tag, "_ack_single"}, 32'(o_wb_ack), 32'd0);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(i) ^ 8'hA5;
        reset = 1'b1;
        i_la_wb_disable = 1'b0;
        i_la_write = 1'b0;
        i_la_addr = '0;
        i_la_data = '0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we = 1'b0;
        i_wb_sel = 4'h0;
        i_wb_addr = '0;
        i_wb_data = '0;
        i_irq_src = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_core_req", 32'(o_core_req), 32'd0);
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_irq", 32'(o_interrupt), 32'd0);
        chk("rst_la_rdata", 32'(o_la_rdata), 32'd0);
        reset = 1'b0;

        // Core write with ready on the second request cycle, then read it back.
        core_delay = 2;
        cw_q.push_back({7'h03, 8'h5A});
        wb_xfer("t1_wr", 1'b1, 32'h0C, 32'h5A, 4'h1, 32'h0, 4, 1'b0);
        core_delay = 1;
        wb_xfer("t1_rd", 1'b0, 32'h0C, 32'h0, 4'h1, 32'h5A, 3, 1'b0);
        wb_xfer("sel0_wr", 1'b1, 32'h14, 32'h33, 4'h2, 32'h0, 2, 1'b0);

        // Timeout path and interrupt clear.
        wb_xfer("mask_wr", 1'b1, 32'h204, 32'h3, 4'hF, 32'h0, 2, 1'b0);
        wb_xfer("mask_rd", 1'b0, 32'h204, 32'h0, 4'hF, 32'h3, 2, 1'b0);
        core_never = 1'b1;
        wb_xfer("t2_to", 1'b0, 32'h10, 32'h0, 4'hF, 32'hFFFF_FFFF, TIMEOUT + 2, 1'b0);
        core_never = 1'b0;
        wb_xfer("t2_status", 1'b0, 32'h200, 32'h0, 4'hF, 32'h2, 2, 1'b0);
        chk("t2_irq_on", 32'(o_interrupt), 32'd1);
        wb_xfer("t2_w1c", 1'b1, 32'h200, 32'h2, 4'hF, 32'h0, 2, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("t2_irq_off", 32'(o_interrupt), 32'd0);

        // Source edge coinciding with W1C keeps the bit set.
        i_irq_src = '1;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_irq_on", 32'(o_interrupt), 32'd1);
        i_irq_src = '0;
        wb_xfer("t5_status", 1'b0, 32'h200, 32'h0, 4'hF, 32'h1, 2, 1'b0);
        wb_xfer("t5_w1c_race", 1'b1, 32'h200, 32'h1, 4'hF, 32'h0, 2, 1'b1);
        wb_xfer("t5_status_kept", 1'b0, 32'h200, 32'h0, 4'hF, 32'h1, 2, 1'b0);
        i_irq_src = '0;
        wb_xfer("t5_w1c", 1'b1, 32'h200, 32'h1, 4'hF, 32'h0, 2, 1'b0);
        wb_xfer("t5_status_clr", 1'b0, 32'h200, 32'h0, 4'hF, 32'h0, 2, 1'b0);

        // Ownership flips mid-access; current access completes, next one is dropped.
        core_delay = 6;
        fork
            wb_xfer("t4_rd", 1'b0, 32'h14, 32'h0, 4'h1, 32'h0000_00A0, 8, 1'b0);
            begin
                repeat (3) @(posedge clock);
                #1;
                i_la_wb_disable = 1'b1;
            end
        join
        core_delay = 1;
        repeat (4) @(posedge clock);
        wb_xfer("t4_wr_drop", 1'b1, 32'h18, 32'h77, 4'h1, 32'h0, 2, 1'b0);
        wb_xfer("t4_rd_zero", 1'b0, 32'h0C, 32'h0, 4'h1, 32'h0, 2, 1'b0);

        // LA write, follow-up read-back, and a concurrent dropped WB write.
        i_la_addr = 7'h22;
        i_la_data = 8'hC3;
        @(posedge clock);
        #1;
        i_la_write = 1'b1;
        cw_q.push_back({7'h22, 8'hC3});
        wb_xfer("t3_wb_drop", 1'b1, 32'h0C, 32'h11, 4'h1, 32'h0, 0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        i_la_write = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("t3_la_rdata", 32'(o_la_rdata), 32'h0000_00C3);
        chk("t3_core_writes_left", 32'(cw_q.size()), 32'd0);
        chk("t3_mem3_intact", 32'(mem[3]), 32'h0000_005A);

        // Reset in the middle of an issued access.
        i_la_wb_disable = 1'b0;
        repeat (4) @(posedge clock);
        core_never = 1'b1;
        @(posedge clock);
        #1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = 32'h0C;
        repeat (3) @(posedge clock);
        #1;
        chk("t6_in_issue", 32'(o_core_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_req_rst", 32'(o_core_req), 32'd0);
        chk("t6_addr_rst", 32'(o_core_addr), 32'd0);
        chk("t6_ack_rst", 32'(o_wb_ack), 32'd0);
        chk("t6_data_rst", o_wb_data, 32'd0);
        chk("t6_la_rdata_rst", 32'(o_la_rdata), 32'd0);
        chk("t6_irq_rst", 32'(o_interrupt), 32'd0);
        @(posedge clock);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        reset    = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (o_wb_ack) acks++;
        end
        chk("t6_no_ack", 32'(acks), 32'd0);
        core_never = 1'b0;
        wb_xfer("t6_info", 1'b0, 32'h208, 32'h0, 4'hF,
                {8'(IRQ_SRC), 8'(DATA_W), 8'(ADDR_W), 8'h01}, 2, 1'b0);
        wb_xfer("t6_mask", 1'b0, 32'h204, 32'h0, 4'hF, 32'h0, 2, 1'b0);
        wb_xfer("t6_csr3", 1'b0, 32'h20C, 32'h0, 4'hF, 32'h0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
